system_cpu_ocm_pipelined: RTL and testbench
===========================================

Name: system_cpu_ocm_pipelined

Overview:
Parametrised single-port on-chip memory for the worker CPUs. It is the Avalon-MM slave behind each CPU's tightly-coupled data/instruction window. It generalises the fixed 128x32 OCM in three ways: configurable width and depth, a selectable read pipeline with explicit readdatavalid, and a hardware clear-on-reset sequencer that zeroes the array before it accepts traffic. The clock-enable and reset-request stall semantics of the previous OCM are kept.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
ADDR_WIDTH, 7, word address width; DEPTH = 2**ADDR_WIDTH.
READ_LATENCY, 1, accepted read to readdatavalid in non-stalled cycles; legal values 1 or 2 (2 adds an output register).
CLEAR_ON_RESET, 1, when 1 the INIT sequencer zeroes every word after reset; when 0 the block goes straight to READY.

Ports:
clk  input  1  single clock; all logic is rising-edge.
reset  input  1  asynchronous, active-high reset.
address  input  ADDR_WIDTH  word address.
byteenable  input  DATA_WIDTH/8  write byte lanes.
chipselect  input  1  slave select.
read  input  1  read request.
write  input  1  write request.
writedata  input  DATA_WIDTH  write data.
clken  input  1  clock enable; 0 = stall.
reset_req  input  1  reset request; 1 = stall.
waitrequest  output  1  high means the request is not accepted.
readdata  output  DATA_WIDTH  read data.
readdatavalid  output  1  readdata valid this cycle.

Behaviour:
- Reset (async assert): state = INIT if CLEAR_ON_RESET, else READY. Init counter = 0, pipeline valid bits = 0, readdatavalid = 0, readdata = 0, waitrequest = 1.
- stall = ~clken | reset_req. During a stall nothing changes state: counter, FSM and pipeline registers all hold. waitrequest = 1 and readdatavalid = 0. readdata holds its value.
- FSM states:
  - INIT: each non-stalled cycle writes 0 to all lanes at the counter address, then increments the counter. After writing DEPTH-1, go to READY. waitrequest = 1 throughout INIT.
  - READY: waitrequest = stall. No other states.
- Clear timing: with reset released before edge 0 and no stalls, INIT occupies edges 0..DEPTH-1. waitrequest is low from the cycle after edge DEPTH-1 (cycle DEPTH).
- Accept: the request is accepted on a rising edge where chipselect & ~waitrequest & (read | write).
- Write: lanes with byteenable[i]=1 are updated at the accepting edge. Other lanes keep their contents. byteenable=0 writes nothing. Writes produce no response.
- Read: the array is a registered-address synchronous read. The valid bit enters a READ_LATENCY-deep shift register. readdatavalid = vld[READ_LATENCY-1] & ~stall. The pipeline advances only on non-stalled edges. Each read produces exactly one readdatavalid beat. Reads are fully pipelined at 1 per cycle.
- read & write together: treated as a write only; no read beat is produced.
- Read after write: a read accepted at the edge after a write to the same address returns the new data. A read and write to the same address on the same edge cannot occur (write wins).
- Address: wraps naturally because DEPTH is a power of two; there is no out-of-range case.
- Reset mid-operation: in-flight read beats are discarded with no valid output. A reset during INIT restarts the clear from address 0.
- reset_req asserted for any duration holds the block; traffic resumes exactly where it paused.

Decomposition:
- Package system_cpu_ocm_pkg holds:
  - the FSM state enum (INIT, READY);
  - the function for byte-lane count;
  - the localparams for legal READ_LATENCY values.
- Sub-module system_cpu_ocm_ram holds the inferred single-port RAM with per-byte write enables and a registered read address, with no reset on the array. The top level contains the FSM, init counter, write mux (init vs bus), and valid/output pipeline.

Test Plan:
- Clear: DEPTH=128, CLEAR_ON_RESET=1, reset pulse. waitrequest stays 1 for exactly 128 cycles. Reads of addresses 0, 64 and 127 all return 0x00000000.
- Byte lanes: write 0xAABBCCDD to addr 5 with byteenable=1111, then 0x11223344 with byteenable=0101. A read of addr 5 returns 0xAA22CC44.
- Pipeline: READ_LATENCY=2, back-to-back reads of addr 1,2,3 holding 0x1,0x2,0x3. readdatavalid is high exactly 2 cycles after each acceptance, 3 consecutive beats, data 0x1,0x2,0x3 in order.
- Stall: clken=0 for 3 cycles while one read is in flight. readdatavalid stays 0 during the stall, and the beat appears after READ_LATENCY non-stalled cycles total. reset_req=1 during INIT freezes the counter, and INIT completes 128 non-stalled cycles after reset.
- Simultaneous read+write: write 0x55 to addr 9 with read=1 → no readdatavalid. A read of addr 9 on the next cycle returns 0x55.
- Reset mid-flight: assert reset one cycle after a read is accepted → no readdatavalid is ever produced for that read, and a new INIT runs from address 0.

Source files
------------

// File: rtl/system_cpu_ocm_pkg.sv
// ============================================================================
// Module  : system_cpu_ocm_pkg
// Brief   : Shared types and constants for the worker-CPU on-chip memory.
// Revision: 1.0
// ============================================================================
`default_nettype none

package system_cpu_ocm_pkg;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } ocm_state_e;

  localparam int c_READ_LATENCY_MIN = 1;
  localparam int c_READ_LATENCY_MAX = 2;

  function automatic int lane_count(input int data_width);
    return data_width / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/system_cpu_ocm_ram.sv
// ============================================================================
// Module  : system_cpu_ocm_ram
// Brief   : Single-port RAM, per-byte write enables, registered read address.
// Revision: 1.0
// ============================================================================
`default_nettype none

module system_cpu_ocm_ram
  import system_cpu_ocm_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                                clk,
  input  logic                                i_en,
  input  logic [ADDR_WIDTH-1:0]               i_addr,
  input  logic [lane_count(DATA_WIDTH)-1:0]   i_we,
  input  logic [DATA_WIDTH-1:0]               i_wdata,
  output logic [DATA_WIDTH-1:0]               o_rdata
);

  localparam int c_LANES = lane_count(DATA_WIDTH);
  localparam int c_DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [0:c_DEPTH-1];
  logic [ADDR_WIDTH-1:0] r_addr;

  // The address register only advances when enabled, so a stalled read holds its output.
  always_ff @(posedge clk) begin
    for (int i = 0; i < c_LANES; i++) begin
      if (i_we[i]) begin
        r_mem[i_addr][i*8 +: 8] <= i_wdata[i*8 +: 8];
      end
    end
    if (i_en) begin
      r_addr <= i_addr;
    end
  end

  assign o_rdata = r_mem[r_addr];

endmodule

`default_nettype wire

// File: rtl/system_cpu_ocm_pipelined.sv
// ============================================================================
// Module  : system_cpu_ocm_pipelined
// Brief   : Avalon-MM OCM with clear-on-reset sequencer and read pipeline.
// Revision: 1.0
// ============================================================================
`default_nettype none

module system_cpu_ocm_pipelined
  import system_cpu_ocm_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 7,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [ADDR_WIDTH-1:0]             address,
  input  logic [lane_count(DATA_WIDTH)-1:0] byteenable,
  input  logic                              chipselect,
  input  logic                              read,
  input  logic                              write,
  input  logic [DATA_WIDTH-1:0]             writedata,
  input  logic                              clken,
  input  logic                              reset_req,
  output logic                              waitrequest,
  output logic [DATA_WIDTH-1:0]             readdata,
  output logic                              readdatavalid
);

  localparam int c_LANES = lane_count(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = '1;

  ocm_state_e            r_state;
  ocm_state_e            w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] w_cnt_nxt;

  logic                  w_stall;
  logic                  w_init;
  logic                  w_accept;
  logic                  w_bus_wr;
  logic                  w_bus_rd;

  logic [ADDR_WIDTH-1:0] w_ram_addr;
  logic [c_LANES-1:0]    w_ram_we;
  logic [DATA_WIDTH-1:0] w_ram_wdata;
  logic [DATA_WIDTH-1:0] w_ram_q;

  logic                  w_vld_out;
  logic [DATA_WIDTH-1:0] w_data_out;
  logic [DATA_WIDTH-1:0] r_last;

  assign w_stall     = ~clken | reset_req;
  assign w_init      = (r_state == ST_INIT);
  assign waitrequest = reset | w_init | w_stall;
  assign w_accept    = chipselect & ~waitrequest & (read | write);
  assign w_bus_wr    = w_accept & write;
  // A combined read+write is serviced as a write only.
  assign w_bus_rd    = w_accept & read & ~write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_READY;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (w_init && !w_stall) begin
      w_cnt_nxt = r_cnt + 1'b1;
      if (r_cnt == c_LAST_ADDR) begin
        w_state_nxt = ST_READY;
      end
    end
  end

  always_comb begin
    w_ram_addr  = w_init ? r_cnt : address;
    w_ram_wdata = w_init ? '0 : writedata;
    w_ram_we    = '0;
    if (w_init && !w_stall) begin
      w_ram_we = '1;
    end else if (w_bus_wr) begin
      w_ram_we = byteenable;
    end
  end

  system_cpu_ocm_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .i_en    (~w_stall),
    .i_addr  (w_ram_addr),
    .i_we    (w_ram_we),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_q)
  );

  generate
    if (READ_LATENCY >= c_READ_LATENCY_MAX) begin : g_lat2
      logic [1:0]            r_vld;
      logic [DATA_WIDTH-1:0] r_q2;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_vld <= '0;
          r_q2  <= '0;
        end else if (!w_stall) begin
          r_vld <= {r_vld[0], w_bus_rd};
          r_q2  <= w_ram_q;
        end
      end

      assign w_vld_out  = r_vld[1];
      assign w_data_out = r_q2;
    end else begin : g_lat1
      logic r_vld;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_vld <= 1'b0;
        end else if (!w_stall) begin
          r_vld <= w_bus_rd;
        end
      end

      assign w_vld_out  = r_vld;
      assign w_data_out = w_ram_q;
    end
  endgenerate

  // Between beats readdata shows the most recently delivered word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last <= '0;
    end else if (w_vld_out && !w_stall) begin
      r_last <= w_data_out;
    end
  end

  assign readdata      = w_vld_out ? w_data_out : r_last;
  assign readdatavalid = w_vld_out & ~w_stall;

endmodule

`default_nettype wire

// File: tb/tb_system_cpu_ocm_pipelined.sv
// ============================================================================
// Module  : tb_system_cpu_ocm_pipelined
// Brief   : Two OCM instances (latency 1 and 2) on shared stimulus vs a model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_system_cpu_ocm_pipelined;

  localparam int DEPTH = 128;

  logic        clk;
  logic        reset;
  logic [6:0]  address;
  logic [3:0]  byteenable;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic        clken;
  logic        reset_req;
  logic        waitrequest1, waitrequest2;
  logic [31:0] readdata1, readdata2;
  logic        readdatavalid1, readdatavalid2;

  system_cpu_ocm_pipelined #(
    .DATA_WIDTH (32), .ADDR_WIDTH (7), .READ_LATENCY (1), .CLEAR_ON_RESET (1)
  ) u_dut1 (
    .clk (clk), .reset (reset), .address (address), .byteenable (byteenable),
    .chipselect (chipselect), .read (read), .write (write), .writedata (writedata),
    .clken (clken), .reset_req (reset_req), .waitrequest (waitrequest1),
    .readdata (readdata1), .readdatavalid (readdatavalid1)
  );

  system_cpu_ocm_pipelined #(
    .DATA_WIDTH (32), .ADDR_WIDTH (7), .READ_LATENCY (2), .CLEAR_ON_RESET (1)
  ) u_dut2 (
    .clk (clk), .reset (reset), .address (address), .byteenable (byteenable),
    .chipselect (chipselect), .read (read), .write (write), .writedata (writedata),
    .clken (clken), .reset_req (reset_req), .waitrequest (waitrequest2),
    .readdata (readdata2), .readdatavalid (readdatavalid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: memory contents, clear countdown and per-latency beat queues.
  typedef struct { logic [31:0] data; int stamp; } beat_t;
  logic [31:0] mem_m [DEPTH];
  int          init_left;
  int          nsc;
  beat_t       q1[$];
  beat_t       q2[$];
  logic [31:0] last1, last2;

  int          checks   = 0;
  int          failures = 0;
  logic        obs_wr;
  logic [31:0] cap2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q1.delete();
    q2.delete();
    last1     = '0;
    last2     = '0;
    init_left = DEPTH;
  endtask

  function automatic logic q_vis(input int lat, input beat_t q[$]);
    return (q.size() > 0) && (nsc - q[0].stamp == lat);
  endfunction

  task automatic tick();
    logic        stall;
    logic        exp_wr;
    logic        v1, v2;
    logic [31:0] d1, d2;
    if (reset) model_reset();
    #1;
    stall  = ~clken | reset_req;
    exp_wr = reset | (init_left != 0) | stall;
    v1 = !stall && q_vis(1, q1);
    v2 = !stall && q_vis(2, q2);
    d1 = q_vis(1, q1) ? q1[0].data : last1;
    d2 = q_vis(2, q2) ? q2[0].data : last2;
    obs_wr = waitrequest1;
    check("waitrequest_l1", {31'd0, waitrequest1}, {31'd0, exp_wr});
    check("waitrequest_l2", {31'd0, waitrequest2}, {31'd0, exp_wr});
    check("rdvalid_l1", {31'd0, readdatavalid1}, {31'd0, v1});
    check("rdvalid_l2", {31'd0, readdatavalid2}, {31'd0, v2});
    check("readdata_l1", readdata1, d1);
    check("readdata_l2", readdata2, d2);
    if (readdatavalid2) cap2 = readdata2;
    @(posedge clk);
    if (!reset && !stall) begin
      if (init_left != 0) begin
        init_left--;
        if (init_left == 0) begin
          for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        end
      end else begin
        if (q_vis(1, q1)) begin last1 = q1[0].data; void'(q1.pop_front()); end
        if (q_vis(2, q2)) begin last2 = q2[0].data; void'(q2.pop_front()); end
        if (chipselect && write) begin
          for (int b = 0; b < 4; b++)
            if (byteenable[b]) mem_m[address][b*8 +: 8] = writedata[b*8 +: 8];
        end else if (chipselect && read) begin
          q1.push_back('{data: mem_m[address], stamp: nsc});
          q2.push_back('{data: mem_m[address], stamp: nsc});
        end
        nsc++;
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic cs, input logic rd, input logic wr,
                       input logic [6:0] a, input logic [3:0] be, input logic [31:0] wd);
    chipselect = cs; read = rd; write = wr; address = a; byteenable = be; writedata = wd;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 1'b0, 7'd0, 4'h0, 32'h0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic op(input logic rd, input logic wr, input logic [6:0] a,
                    input logic [3:0] be, input logic [31:0] wd);
    drive(1'b1, rd, wr, a, be, wd);
    tick();
  endtask

  initial begin
    int n;
    reset = 1'b1; clken = 1'b1; reset_req = 1'b0; nsc = 0; cap2 = '0;
    drive(1'b0, 1'b0, 1'b0, 7'd0, 4'h0, 32'h0);
    model_reset();
    @(negedge clk);
    tick();
    tick();
    reset = 1'b0;

    // Clear sequence: waitrequest high for exactly DEPTH cycles.
    n = 0;
    do begin
      tick();
      if (obs_wr) n++;
    end while (obs_wr && n < 400);
    check("clear_wait_cycles", n, DEPTH);

    op(1'b1, 1'b0, 7'd0,   4'h0, 32'h0);
    op(1'b1, 1'b0, 7'd64,  4'h0, 32'h0);
    op(1'b1, 1'b0, 7'd127, 4'h0, 32'h0);
    idle(3);

    op(1'b0, 1'b1, 7'd5, 4'hF, 32'hAABBCCDD);
    op(1'b0, 1'b1, 7'd5, 4'h5, 32'h11223344);
    op(1'b0, 1'b1, 7'd6, 4'h0, 32'hFFFFFFFF);
    op(1'b1, 1'b0, 7'd5, 4'h0, 32'h0);
    idle(3);
    check("byte_lanes_addr5", cap2, 32'hAA22CC44);

    op(1'b0, 1'b1, 7'd1, 4'hF, 32'h1);
    op(1'b0, 1'b1, 7'd2, 4'hF, 32'h2);
    op(1'b0, 1'b1, 7'd3, 4'hF, 32'h3);
    op(1'b1, 1'b0, 7'd1, 4'h0, 32'h0);
    op(1'b1, 1'b0, 7'd2, 4'h0, 32'h0);
    op(1'b1, 1'b0, 7'd3, 4'h0, 32'h0);
    idle(4);

    op(1'b1, 1'b0, 7'd2, 4'h0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 7'd0, 4'h0, 32'h0);
    clken = 1'b0;
    tick(); tick(); tick();
    clken = 1'b1;
    idle(3);

    op(1'b1, 1'b1, 7'd9, 4'hF, 32'h55);
    op(1'b1, 1'b0, 7'd9, 4'h0, 32'h0);
    idle(3);
    check("rw_then_read_addr9", cap2, 32'h55);

    // Reset one cycle after an accepted read, then a clear with reset_req stalls.
    op(1'b1, 1'b0, 7'd5, 4'h0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 7'd0, 4'h0, 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n = 0;
    for (int k = 0; k < 1000; k++) begin
      reset_req = ($urandom_range(0, 3) == 0);
      if (k > 900) reset_req = 1'b0;
      tick();
      if (obs_wr && !reset_req) n++;
      if (!obs_wr) break;
    end
    reset_req = 1'b0;
    check("stalled_clear_cycles", n, DEPTH);
    op(1'b1, 1'b0, 7'd5, 4'h0, 32'h0);
    idle(3);

    for (int k = 0; k < 2000; k++) begin
      clken     = ($urandom_range(0, 9) != 0);
      reset_req = ($urandom_range(0, 19) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
            7'($urandom_range(0, 15)), 4'($urandom), $urandom);
      tick();
    end
    clken = 1'b1; reset_req = 1'b0;
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
